// File: rtl/fft_pkg.sv
// fft_pkg: shared frame-size encoding, index helpers and read-side state type
// for the FFT output reorder stage.
package fft_pkg;

   localparam logic [1:0] SEL_16  = 2'b00;
   localparam logic [1:0] SEL_32  = 2'b11;
   localparam logic [1:0] SEL_64  = 2'b01;
   localparam logic [1:0] SEL_128 = 2'b10;
   localparam int         IDX_W   = 8;

   typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;

   function automatic int log2c(input int v);
      for (int r = 0; r < 31; r++)
         if ((1 << r) >= v) return r;
      return 31;
   endfunction

   function automatic logic [3:0] sel2log(input logic [1:0] s);
      return (s == SEL_128) ? 4'd7 : (s == SEL_64) ? 4'd6 : (s == SEL_32) ? 4'd5 : 4'd4;
   endfunction

   // Reverses the low nbits of idx; bits above nbits come out as zero.
   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx, input logic [3:0] nbits);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < IDX_W; i++)
         for (int k = 0; k < IDX_W; k++)
            if (i < int'(nbits) && k == int'(nbits) - 1 - i) r[i] = idx[k];
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two-bank sample store, one synchronous write port and one
// synchronous read port; the bank select is the address MSB.
module fft_pingpong_ram #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: turns bit-reversed FFT output frames into natural order
// using ping-pong banks so input frames can arrive back-to-back.
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int MAX_N = 128,
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [1:0]       sel_i,
   input  logic             di_en_i,
   input  logic [WIDTH-1:0] di_re_i,
   input  logic [WIDTH-1:0] di_im_i,
   output logic             do_en_o,
   output logic [WIDTH-1:0] do_re_o,
   output logic [WIDTH-1:0] do_im_o
);

   localparam int LG = log2c(MAX_N);

   rd_state_e          st_q, st_d;
   logic [LG-1:0]      wc_q, wc_d, rc_q, rc_d, wr_idx;
   logic [3:0]         wlg_q, wlg_d, rlg_q, rlg_d, plg_q, plg_d, lg_cur;
   logic               wbank_q, wbank_d, rbank_q, rbank_d, pbank_q, pbank_d;
   logic               pend_q, pend_d, rv_q, en_q, done, last_rd, take;
   logic [WIDTH-1:0]   re_q, im_q;
   logic [2*WIDTH-1:0] rdata;

   always_comb begin
      lg_cur  = (wc_q == '0) ? sel2log(sel_i) : wlg_q;
      done    = di_en_i && wc_q == LG'((32'd1 << lg_cur) - 32'd1);
      wc_d    = !di_en_i ? wc_q : done ? '0 : wc_q + 1'b1;
      wlg_d   = di_en_i ? lg_cur : wlg_q;
      wbank_d = wbank_q ^ done;
      wr_idx  = LG'(bitrev(IDX_W'(wc_q), lg_cur));
      last_rd = st_q == RD_RUN && rc_q == LG'((32'd1 << rlg_q) - 32'd1);
      take    = st_q == RD_IDLE || last_rd;
      // A frame completing while the reader is free starts reading next cycle
      // without passing through the pending slot.
      st_d    = take ? ((pend_q || done) ? RD_RUN : RD_IDLE) : st_q;
      rc_d    = take ? '0 : rc_q + 1'b1;
      rbank_d = !take ? rbank_q : pend_q ? pbank_q : wbank_q;
      rlg_d   = !take ? rlg_q : pend_q ? plg_q : lg_cur;
      pend_d  = (pend_q && !take) || (done && !(take && !pend_q));
      pbank_d = done ? wbank_q : pbank_q;
      plg_d   = done ? lg_cur : plg_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q    <= RD_IDLE;
         wc_q    <= '0;
         rc_q    <= '0;
         wlg_q   <= 4'd4;
         rlg_q   <= 4'd4;
         plg_q   <= 4'd4;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         pbank_q <= 1'b0;
         pend_q  <= 1'b0;
         rv_q    <= 1'b0;
         en_q    <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
      end else begin
         st_q    <= st_d;
         wc_q    <= wc_d;
         rc_q    <= rc_d;
         wlg_q   <= wlg_d;
         rlg_q   <= rlg_d;
         plg_q   <= plg_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         pbank_q <= pbank_d;
         pend_q  <= pend_d;
         rv_q    <= st_q == RD_RUN;
         en_q    <= rv_q;
         if (rv_q) {re_q, im_q} <= rdata;
      end
   end

   fft_pingpong_ram #(.AW(LG + 1), .DW(2 * WIDTH)) u_ram (
      .clk_i   (clk_i),
      .we_i    (di_en_i),
      .waddr_i ({wbank_q, wr_idx}),
      .wdata_i ({di_re_i, di_im_i}),
      .raddr_i ({rbank_q, rc_q}),
      .rdata_o (rdata)
   );

   assign do_en_o = en_q;
   assign do_re_o = re_q;
   assign do_im_o = im_q;

endmodule
